// File: rtl/mod_counter_ctrl.sv
// mod_counter_ctrl
//   Run/stop controlled modulo-MOD up/down counter. A prescaler divides clk
//   by TICK_DIV to produce the count step; every output comes straight from
//   a flop.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   run_stop    in   pulse: toggles STOP <-> RUN
//   clear       in   pulse: zero count and prescaler, go to CLEAR then STOP
//   mode        in   direction, 0 = up, 1 = down (sampled on steps only)
//   load        in   pulse: load load_value (saturated to MOD-1)
//   load_value  in   [WIDTH-1:0] value written by load
//   count_data  out  [WIDTH-1:0] current count
//   running     out  high while the FSM is in RUN
//   wrap        out  one-cycle pulse when the count takes its wrapped value
//
// state | meaning
// ------+--------------------------------------------------------------
// STOP  | idle, count and prescaler hold
// RUN   | prescaler advances, count steps on every prescaler tick
// CLEAR | one-cycle clear; count/prescaler forced to 0, load ignored

module mod_counter_ctrl #(
    parameter int MOD      = 10000,
    parameter int WIDTH    = 14,
    parameter int TICK_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_stop,
    input  logic             clear,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count_data,
    output logic             running,
    output logic             wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    prescaler, pre_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             running_nxt;
    logic             wrap_nxt;
    logic             tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_STOP;
            prescaler  <= '0;
            count_data <= '0;
            running    <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state      <= state_nxt;
            prescaler  <= pre_nxt;
            count_data <= count_nxt;
            running    <= running_nxt;
            wrap       <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = prescaler;
        count_nxt = count_data;
        wrap_nxt  = 1'b0;
        tick      = 1'b0;

        if (clear) begin
            state_nxt = ST_CLEAR;
            pre_nxt   = '0;
            count_nxt = '0;
        end else begin
            unique case (state)
                ST_STOP:  if (run_stop) state_nxt = ST_RUN;
                ST_RUN:   if (run_stop) state_nxt = ST_STOP;
                ST_CLEAR: state_nxt = ST_STOP;
                default:  state_nxt = ST_STOP;
            endcase

            if (state != ST_CLEAR) begin
                if (load) begin
                    // a load also swallows any tick landing in the same cycle
                    count_nxt = (load_value > MAX_VAL) ? MAX_VAL : load_value;
                    pre_nxt   = '0;
                end else if (state == ST_RUN) begin
                    if (prescaler == PRE_LAST) begin
                        pre_nxt = '0;
                        tick    = 1'b1;
                    end else begin
                        pre_nxt = prescaler + PW'(1);
                    end
                end
            end

            if (tick) begin
                if (!mode) begin
                    if (count_data == MAX_VAL) begin
                        count_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end else begin
                        count_nxt = count_data + WIDTH'(1);
                    end
                end else begin
                    if (count_data == '0) begin
                        count_nxt = MAX_VAL;
                        wrap_nxt  = 1'b1;
                    end else begin
                        count_nxt = count_data - WIDTH'(1);
                    end
                end
            end
        end

        running_nxt = (state_nxt == ST_RUN);
    end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// tb_mod_counter_ctrl
//   Drives two instances from the same inputs: the reference configuration
//   (MOD=10, WIDTH=4, TICK_DIV=4) and a boundary one (MOD=16=2^WIDTH,
//   TICK_DIV=1). Both are compared every cycle against a behavioural model.

module tb_mod_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run_stop = 1'b0;
    logic       clear = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic [3:0] count_data0, count_data1;
    logic       running0, running1, wrap0, wrap1;

    int vectors = 0;
    int miscompares = 0;

    int m_count [2];
    int m_phase [2];
    bit m_run   [2];
    bit m_clr   [2];
    bit m_wrap  [2];
    int mod_c   [2] = '{10, 16};
    int td_c    [2] = '{4, 1};

    always #5 clk = ~clk;

    mod_counter_ctrl #(.MOD(10), .WIDTH(4), .TICK_DIV(4)) u_dut (
        .clk(clk), .reset(reset), .run_stop(run_stop), .clear(clear),
        .mode(mode), .load(load), .load_value(load_value),
        .count_data(count_data0), .running(running0), .wrap(wrap0)
    );

    mod_counter_ctrl #(.MOD(16), .WIDTH(4), .TICK_DIV(1)) u_fast (
        .clk(clk), .reset(reset), .run_stop(run_stop), .clear(clear),
        .mode(mode), .load(load), .load_value(load_value),
        .count_data(count_data1), .running(running1), .wrap(wrap1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        assert (obs === 32'(exp)) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        vectors++;
        chk({where, " count0"},   {28'd0, count_data0}, m_count[0]);
        chk({where, " running0"}, {31'd0, running0},    int'(m_run[0]));
        chk({where, " wrap0"},    {31'd0, wrap0},       int'(m_wrap[0]));
        chk({where, " count1"},   {28'd0, count_data1}, m_count[1]);
        chk({where, " running1"}, {31'd0, running1},    int'(m_run[1]));
        chk({where, " wrap1"},    {31'd0, wrap1},       int'(m_wrap[1]));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0; m_phase[k] = 0; m_run[k] = 0;
            m_clr[k] = 0;   m_wrap[k] = 0;
        end
    endtask

    // One clock edge of the intended behaviour, using plain modular arithmetic.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 0;
            if (clear) begin
                m_clr[k] = 1; m_count[k] = 0; m_phase[k] = 0; m_run[k] = 0;
            end else if (m_clr[k]) begin
                m_clr[k] = 0;
            end else begin
                if (load) begin
                    m_count[k] = (int'(load_value) > mod_c[k] - 1) ? mod_c[k] - 1 : int'(load_value);
                    m_phase[k] = 0;
                end else if (m_run[k]) begin
                    if (m_phase[k] == td_c[k] - 1) begin
                        m_phase[k] = 0;
                        if (!mode) begin
                            m_count[k] = (m_count[k] + 1) % mod_c[k];
                            m_wrap[k]  = (m_count[k] == 0);
                        end else begin
                            m_wrap[k]  = (m_count[k] == 0);
                            m_count[k] = (m_count[k] + mod_c[k] - 1) % mod_c[k];
                        end
                    end else begin
                        m_phase[k]++;
                    end
                end
                if (run_stop) m_run[k] = !m_run[k];
            end
        end
    endtask

    task automatic cycle(input logic rs, input logic cl, input logic ld,
                         input logic md, input logic [3:0] lv);
        run_stop = rs; clear = cl; load = ld; mode = md; load_value = lv;
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
        run_stop = 0; clear = 0; load = 0;
    endtask

    // Called 1 time unit after an edge: assert reset mid-interval and check
    // that outputs drop before the next edge, then hold with garbage inputs.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        for (int i = 0; i < 2; i++) begin
            run_stop = 1'($urandom); clear = 1'($urandom); load = 1'($urandom);
            mode = 1'($urandom); load_value = 4'($urandom);
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        run_stop = 0; clear = 0; load = 0; mode = 0;
        #3;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        check_all("rst_init");
        @(posedge clk);
        #1;
        check_all("rst_init_edge");
        #3;
        reset = 1'b0;

        // up count through a full wrap
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 44; i++) cycle(0, 0, 0, 0, 0);

        // down count through 0 -> MOD-1
        for (int i = 0; i < 45; i++) cycle(0, 0, 0, 1, 0);

        // stop two cycles after a step, hold, resume
        for (int i = 0; i < 8 && !(m_phase[0] == 0 && m_run[0]); i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);

        // loads in STOP, including saturation
        if (m_run[0]) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 4'd7);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 4'd12);
        cycle(0, 0, 0, 0, 0);

        // clear + run_stop + load together while running at 5
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 4'd5);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 4'd3);
        cycle(1, 0, 1, 0, 4'd3);
        cycle(0, 0, 0, 0, 0);

        // async reset mid-interval at count 6, then a full restart interval
        cycle(1, 0, 1, 0, 4'd6);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        do_reset();
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 400 == 399) begin
                do_reset();
            end else begin
                logic m;
                m = (i % 50 < 25) ? 1'b0 : 1'b1;
                if ($urandom_range(0, 9) == 0) m = 1'($urandom);
                cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 79) == 0),
                      ($urandom_range(0, 29) == 0), m, 4'($urandom_range(0, 15)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
